// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase codes, lamp patterns, default dwells
// and the legal phase successor function.
package tl_pkg;

    typedef enum logic [2:0] {
        PH_Y1Y2 = 3'd0,
        PH_R1Y2 = 3'd1,
        PH_G1R2 = 3'd2,
        PH_Y1R2 = 3'd3,
        PH_R1G2 = 3'd4,
        PH_ILL  = 3'd7
    } phase_e;

    // Lamp vectors are ordered {red1, yellow1, green1, red2, yellow2, green2}.
    localparam logic [5:0] LAMP_Y1Y2 = 6'b010_010;
    localparam logic [5:0] LAMP_R1Y2 = 6'b100_010;
    localparam logic [5:0] LAMP_G1R2 = 6'b001_100;
    localparam logic [5:0] LAMP_Y1R2 = 6'b010_100;
    localparam logic [5:0] LAMP_R1G2 = 6'b100_001;

    localparam int unsigned DW_Y1Y2_DEF = 32'd2;
    localparam int unsigned DW_R1Y2_DEF = 32'd249;
    localparam int unsigned DW_G1R2_DEF = 32'd2500;
    localparam int unsigned DW_Y1R2_DEF = 32'd250;
    localparam int unsigned DW_R1G2_DEF = 32'd2250;

    function automatic logic [2:0] next_phase(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            PH_Y1Y2: nxt = PH_R1Y2;
            PH_R1Y2: nxt = PH_G1R2;
            PH_G1R2: nxt = PH_Y1R2;
            PH_Y1R2: nxt = PH_R1G2;
            PH_R1G2: nxt = PH_Y1Y2;
            default: nxt = PH_ILL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Combinational decoder from the six lamp bits to a phase code plus legal flag.
module tl_lamp_decode
    import tl_pkg::*;
(
    input  logic [5:0] lamps_i,
    output logic [2:0] code_o,
    output logic       legal_o
);

    // Exact-match decode; any other combination is illegal
    always_comb begin
        code_o  = PH_ILL;
        legal_o = 1'b0;
        case (lamps_i)
            LAMP_Y1Y2: begin code_o = PH_Y1Y2; legal_o = 1'b1; end
            LAMP_R1Y2: begin code_o = PH_R1Y2; legal_o = 1'b1; end
            LAMP_G1R2: begin code_o = PH_G1R2; legal_o = 1'b1; end
            LAMP_Y1R2: begin code_o = PH_Y1R2; legal_o = 1'b1; end
            LAMP_R1G2: begin code_o = PH_R1G2; legal_o = 1'b1; end
            default:   begin code_o = PH_ILL;  legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-pattern checker: phase decode, dwell measurement, order/time/pattern errors.
// Optional error capture registers are built when TLM_CAPTURE_EN is defined.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned DW_Y1Y2 = DW_Y1Y2_DEF,
    parameter int unsigned DW_R1Y2 = DW_R1Y2_DEF,
    parameter int unsigned DW_G1R2 = DW_G1R2_DEF,
    parameter int unsigned DW_Y1R2 = DW_Y1R2_DEF,
    parameter int unsigned DW_R1G2 = DW_R1G2_DEF,
    parameter int unsigned TOL     = 0
) (
    input  logic             clk,
    input  logic             ret,
    input  logic             red1,
    input  logic             yellow1,
    input  logic             green1,
    input  logic             red2,
    input  logic             yellow2,
    input  logic             green2,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [15:0]      cycles,
    output logic             err_pat,
    output logic             err_order,
    output logic             err_time
`ifdef TLM_CAPTURE_EN
    ,
    output logic [2:0]       cap_phase,
    output logic [CNT_W-1:0] cap_dwell,
    output logic [2:0]       cap_code
`endif
);

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

    logic [2:0]       code_s;
    logic             legal_s;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [15:0]      cycles_q, cycles_d;
    logic             err_pat_q, err_pat_d;
    logic             err_order_q, err_order_d;
    logic             err_time_q, err_time_d;
    logic             first_q, first_d;
    logic             change_s, step_s;
    logic             new_pat_s, new_order_s, new_time_s;
    int unsigned      exp_s, lo_s, hi_s;

    function automatic int unsigned exp_dw(input logic [2:0] code);
        int unsigned dw;
        case (code)
            PH_Y1Y2: dw = DW_Y1Y2;
            PH_R1Y2: dw = DW_R1Y2;
            PH_G1R2: dw = DW_G1R2;
            PH_Y1R2: dw = DW_Y1R2;
            PH_R1G2: dw = DW_R1G2;
            default: dw = 32'd0;
        endcase
        return dw;
    endfunction

    tl_lamp_decode u_decode (
        .lamps_i ({red1, yellow1, green1, red2, yellow2, green2}),
        .code_o  (code_s),
        .legal_o (legal_s)
    );

    // Next-state: dwell counting, legal-step checks, overrun and sticky flags
    always_comb begin
        change_s    = (code_s != phase_q);
        step_s      = change_s && legal_s && (phase_q != PH_ILL);
        exp_s       = exp_dw(phase_q);
        lo_s        = (exp_s > TOL) ? (exp_s - TOL) : 32'd0;
        hi_s        = exp_s + TOL;
        phase_d     = code_s;
        cycles_d    = cycles_q;
        new_pat_s   = !legal_s;
        new_order_s = 1'b0;
        new_time_s  = 1'b0;
        if (change_s) begin
            dwell_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            dwell_d = dwell_q;
        end
        if (step_s) begin
            new_order_s = (code_s != next_phase(phase_q));
            new_time_s  = !first_q && ((32'(dwell_q) < lo_s) || (32'(dwell_q) > hi_s));
            if ((phase_q == PH_R1G2) && (code_s == PH_Y1Y2)) begin
                cycles_d = cycles_q + 16'd1;
            end else begin
                cycles_d = cycles_q;
            end
        end else begin
            // Overrun fires as soon as the count passes the window
            new_time_s = legal_s && !change_s && !first_q && (32'(dwell_d) == hi_s + 32'd1);
        end
        if (!legal_s) begin
            first_d = 1'b1;
        end else if (step_s) begin
            first_d = 1'b0;
        end else begin
            first_d = first_q;
        end
        err_pat_d   = (err_pat_q   && !clr_err) || new_pat_s;
        err_order_d = (err_order_q && !clr_err) || new_order_s;
        err_time_d  = (err_time_q  && !clr_err) || new_time_s;
    end

    // Monitor state registers
    always_ff @(posedge clk or posedge ret) begin
        if (ret) begin
            phase_q     <= PH_ILL;
            dwell_q     <= {CNT_W{1'b0}};
            cycles_q    <= 16'd0;
            err_pat_q   <= 1'b0;
            err_order_q <= 1'b0;
            err_time_q  <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            dwell_q     <= dwell_d;
            cycles_q    <= cycles_d;
            err_pat_q   <= err_pat_d;
            err_order_q <= err_order_d;
            err_time_q  <= err_time_d;
            first_q     <= first_d;
        end
    end

    assign phase     = phase_q;
    assign dwell     = dwell_q;
    assign cycles    = cycles_q;
    assign err_pat   = err_pat_q;
    assign err_order = err_order_q;
    assign err_time  = err_time_q;

`ifdef TLM_CAPTURE_EN
    logic             cap_valid_q;
    logic [2:0]       cap_phase_q;
    logic [CNT_W-1:0] cap_dwell_q;
    logic [2:0]       cap_code_q;
    logic             any_new_s;

    assign any_new_s = new_pat_s || new_order_s || new_time_s;

    // Snapshot of the first error since reset or the last clear
    always_ff @(posedge clk or posedge ret) begin
        if (ret) begin
            cap_valid_q <= 1'b0;
            cap_phase_q <= 3'd0;
            cap_dwell_q <= {CNT_W{1'b0}};
            cap_code_q  <= 3'd0;
        end else if (any_new_s && (clr_err || !cap_valid_q)) begin
            cap_valid_q <= 1'b1;
            cap_phase_q <= phase_d;
            cap_dwell_q <= dwell_d;
            cap_code_q  <= {new_time_s, new_order_s, new_pat_s};
        end else if (clr_err) begin
            cap_valid_q <= 1'b0;
            cap_phase_q <= 3'd0;
            cap_dwell_q <= {CNT_W{1'b0}};
            cap_code_q  <= 3'd0;
        end else begin
            cap_valid_q <= cap_valid_q;
            cap_phase_q <= cap_phase_q;
            cap_dwell_q <= cap_dwell_q;
            cap_code_q  <= cap_code_q;
        end
    end

    assign cap_phase = cap_phase_q;
    assign cap_dwell = cap_dwell_q;
    assign cap_code  = cap_code_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor (default build, default parameters).
module tb_traffic_light_monitor;

    localparam logic [5:0] L_Y1Y2 = 6'b010_010;
    localparam logic [5:0] L_R1Y2 = 6'b100_010;
    localparam logic [5:0] L_G1R2 = 6'b001_100;
    localparam logic [5:0] L_Y1R2 = 6'b010_100;
    localparam logic [5:0] L_R1G2 = 6'b100_001;
    localparam logic [5:0] L_BAD  = 6'b001_001;

    logic        clk = 1'b0;
    logic        ret;
    logic        red1, yellow1, green1, red2, yellow2, green2;
    logic        clr_err;
    logic [2:0]  phase;
    logic [11:0] dwell;
    logic [15:0] cycles;
    logic        err_pat, err_order, err_time;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    logic [2:0]  m_phase;
    int          m_dwell;
    logic [15:0] m_cycles;
    logic        m_pat, m_ord, m_time, m_first;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk       (clk),
        .ret       (ret),
        .red1      (red1),
        .yellow1   (yellow1),
        .green1    (green1),
        .red2      (red2),
        .yellow2   (yellow2),
        .green2    (green2),
        .clr_err   (clr_err),
        .phase     (phase),
        .dwell     (dwell),
        .cycles    (cycles),
        .err_pat   (err_pat),
        .err_order (err_order),
        .err_time  (err_time)
    );

    function automatic logic [63:0] pack(input logic [2:0] p, input logic [11:0] d,
                                         input logic [15:0] c, input logic pa,
                                         input logic o, input logic t);
        return {30'd0, p, d, c, pa, o, t};
    endfunction

    function automatic logic [2:0] m_decode(input logic [5:0] l);
        if (l == L_Y1Y2) return 3'd0;
        if (l == L_R1Y2) return 3'd1;
        if (l == L_G1R2) return 3'd2;
        if (l == L_Y1R2) return 3'd3;
        if (l == L_R1G2) return 3'd4;
        return 3'd7;
    endfunction

    function automatic logic [2:0] m_succ(input logic [2:0] c);
        if (c == 3'd4) return 3'd0;
        return c + 3'd1;
    endfunction

    function automatic int m_exp(input logic [2:0] c);
        case (c)
            3'd0:    return 2;
            3'd1:    return 249;
            3'd2:    return 2500;
            3'd3:    return 250;
            3'd4:    return 2250;
            default: return 0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase  = 3'd7;
        m_dwell  = 0;
        m_cycles = 16'd0;
        m_pat    = 1'b0;
        m_ord    = 1'b0;
        m_time   = 1'b0;
        m_first  = 1'b1;
        exp_q.delete();
    endtask

    function automatic logic [63:0] dut_state();
        return pack(phase, dwell, cycles, err_pat, err_order, err_time);
    endfunction

    task automatic step(input logic [5:0] lamps, input logic clr, input string tag);
        logic [2:0] code;
        logic npat, nord, ntim;
        code = m_decode(lamps);
        npat = (code == 3'd7);
        nord = 1'b0;
        ntim = 1'b0;
        if (code != m_phase) begin
            if (code != 3'd7 && m_phase != 3'd7) begin
                nord = (code != m_succ(m_phase));
                ntim = !m_first && (m_dwell != m_exp(m_phase));
                if (m_phase == 3'd4 && code == 3'd0) m_cycles = m_cycles + 16'd1;
                m_first = 1'b0;
            end
            m_dwell = 1;
        end else begin
            if (m_dwell < 4095) m_dwell = m_dwell + 1;
            if (code != 3'd7 && !m_first && m_dwell == m_exp(code) + 1) ntim = 1'b1;
        end
        if (code == 3'd7) m_first = 1'b1;
        m_phase = code;
        m_pat  = (m_pat  && !clr) || npat;
        m_ord  = (m_ord  && !clr) || nord;
        m_time = (m_time && !clr) || ntim;
        exp_q.push_back(pack(m_phase, 12'(m_dwell), m_cycles, m_pat, m_ord, m_time));
        {red1, yellow1, green1, red2, yellow2, green2} = lamps;
        clr_err = clr;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check_eq(tag, dut_state(), exp_q.pop_front());
    endtask

    task automatic hold(input logic [5:0] lamps, input int n, input string tag);
        for (int i = 0; i < n; i++) step(lamps, 1'b0, tag);
    endtask

    task automatic run_loop();
        hold(L_R1Y2, 249, "loop_r1y2");
        hold(L_G1R2, 2500, "loop_g1r2");
        hold(L_Y1R2, 250, "loop_y1r2");
        hold(L_R1G2, 2250, "loop_r1g2");
        hold(L_Y1Y2, 2, "loop_y1y2");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ret     = 1'b1;
        clr_err = 1'b0;
        {red1, yellow1, green1, red2, yellow2, green2} = L_Y1Y2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", dut_state(), pack(3'd7, 12'd0, 16'd0, 1'b0, 1'b0, 1'b0));
        ret = 1'b0;

        // 1: three clean loops
        hold(L_Y1Y2, 2, "t1_bringup");
        repeat (3) run_loop();
        check_eq("t1_cycles", 64'(cycles), 64'd3);
        check_eq("t1_errs", 64'({err_pat, err_order, err_time}), 64'd0);
        check_eq("t1_phase", 64'(phase), 64'd0);

        // 2: G1R2 overrun
        hold(L_R1Y2, 249, "t2_r1y2");
        hold(L_G1R2, 2500, "t2_g1r2");
        check_eq("t2_at_limit", 64'(err_time), 64'd0);
        step(L_G1R2, 1'b0, "t2_over");
        check_eq("t2_dwell", 64'(dwell), 64'd2501);
        check_eq("t2_err_time", 64'(err_time), 64'd1);
        check_eq("t2_err_order", 64'(err_order), 64'd0);
        step(L_Y1R2, 1'b0, "t2_exit");
        step(L_Y1R2, 1'b1, "t2_clr");
        check_eq("t2_cleared", 64'({err_pat, err_order, err_time}), 64'd0);

        // 3: skip from R1Y2 straight to Y1R2
        hold(L_Y1R2, 248, "t3_y1r2");
        hold(L_R1G2, 2250, "t3_r1g2");
        hold(L_Y1Y2, 2, "t3_y1y2");
        hold(L_R1Y2, 249, "t3_r1y2");
        step(L_Y1R2, 1'b0, "t3_skip");
        check_eq("t3_err_order", 64'(err_order), 64'd1);
        check_eq("t3_err_time", 64'(err_time), 64'd0);

        // 4: illegal pattern then fresh start
        step(L_Y1R2, 1'b1, "t4_clr");
        check_eq("t4_cleared", 64'({err_pat, err_order, err_time}), 64'd0);
        step(L_BAD, 1'b0, "t4_bad");
        check_eq("t4_phase_ill", 64'(phase), 64'd7);
        check_eq("t4_err_pat", 64'(err_pat), 64'd1);
        step(L_R1G2, 1'b0, "t4_fresh");
        check_eq("t4_no_order", 64'(err_order), 64'd0);
        check_eq("t4_dwell1", 64'(dwell), 64'd1);
        hold(L_R1G2, 9, "t4_r1g2");
        step(L_R1G2, 1'b1, "t4_clr2");
        step(L_Y1Y2, 1'b0, "t4_exit");
        check_eq("t4_first_unchecked", 64'({err_pat, err_order, err_time}), 64'd0);

        // 5: clear colliding with a new order error
        step(L_Y1Y2, 1'b0, "t5_y1y2");
        step(L_G1R2, 1'b1, "t5_collide");
        check_eq("t5_stays", 64'(err_order), 64'd1);
        step(L_G1R2, 1'b1, "t5_clr");
        check_eq("t5_cleared", 64'({err_pat, err_order, err_time}), 64'd0);

        // 6: reset mid-R1G2
        hold(L_G1R2, 2498, "t6_g1r2");
        hold(L_Y1R2, 250, "t6_y1r2");
        hold(L_R1G2, 1000, "t6_r1g2");
        check_eq("t6_dwell", 64'(dwell), 64'd1000);
        ret = 1'b1;
        #2;
        check_eq("t6_async_rst", dut_state(), pack(3'd7, 12'd0, 16'd0, 1'b0, 1'b0, 1'b0));
        {red1, yellow1, green1, red2, yellow2, green2} = L_Y1Y2;
        model_reset();
        @(posedge clk);
        #1;
        ret = 1'b0;
        step(L_Y1Y2, 1'b0, "t6_bringup");
        hold(L_R1Y2, 3, "t6_r1y2");
        check_eq("t6_no_err", 64'({err_pat, err_order, err_time}), 64'd0);
        check_eq("t6_phase", 64'(phase), 64'd1);

        // dwell saturation
        hold(L_R1Y2, 4100, "sat_r1y2");
        check_eq("sat_dwell", 64'(dwell), 64'd4095);
        check_eq("sat_err_time", 64'(err_time), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
